// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator for the clk_50 domain. A clock-enable divider
//   produces one pix_ce every CLK_DIV cycles. Each pix_ce advances the pixel
//   position (x, y) through the raster in line order active / front porch /
//   sync / back porch. Sync, display enable and the line/frame strobes are
//   registered on the same edge as x and y, so all outputs are mutually aligned.
//
// Ports
//   clk_50       in   system clock, the only clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   1 = run, 0 = freeze divider and counters
//   pix_ce       out  one-cycle pixel clock enable
//   hsync/vsync  out  sync outputs, asserted level set by HSYNC_POL/VSYNC_POL
//   disp_en      out  1 while (x, y) lies in the visible area
//   x, y         out  current pixel column / line
//   line_start   out  one-cycle strobe, x just became 0
//   frame_start  out  one-cycle strobe, x and y just became 0
//   pre_x/pre_y  out  coordinates the next pix_ce will present
//   pre_valid    out  the next pixel is visible
//
// Configuration macro
//   VGA_TIMING_PREFETCH_EN  adds pre_x, pre_y and pre_valid. They give the
//                           frame-buffer reader a full pixel period of latency.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CNT_W     = 10
) (
   input  logic             clk_50,
   input  logic             reset_n,
   input  logic             enable,
   output logic             pix_ce,
   output logic             hsync,
   output logic             vsync,
   output logic             disp_en,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
   ,
   output logic [CNT_W-1:0] pre_x,
   output logic [CNT_W-1:0] pre_y,
   output logic             pre_valid
`endif
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_cnt_w_too_small
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end

   typedef struct packed {
      logic [CNT_W-1:0] x;
      logic [CNT_W-1:0] y;
   } pos_t;

   // Raster position that follows p, wrapping at line and frame ends.
   function automatic pos_t advance(input pos_t p);
      pos_t n;
      n = p;
      if (int'(p.x) == H_TOTAL - 1) begin
         n.x = '0;
         n.y = (int'(p.y) == V_TOTAL - 1) ? '0 : p.y + 1'b1;
      end else begin
         n.x = p.x + 1'b1;
      end
      return n;
   endfunction

   function automatic logic hs_active(input pos_t p);
      return (int'(p.x) >= HS_START) && (int'(p.x) < HS_END);
   endfunction

   function automatic logic vs_active(input pos_t p);
      return (int'(p.y) >= VS_START) && (int'(p.y) < VS_END);
   endfunction

   function automatic logic visible(input pos_t p);
      return (int'(p.x) < H_ACTIVE) && (int'(p.y) < V_ACTIVE);
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic             step;
   pos_t             cur;
   pos_t             nxt;

   assign cur  = '{x: x, y: y};
   assign nxt  = advance(cur);
   // The pixel advances on the same edge that raises pix_ce, so every output
   // below is registered together and carries no relative skew.
   assign step = enable && (div_cnt == DIV_W'(CLK_DIV - 1));

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt     <= '0;
         pix_ce      <= 1'b0;
         x           <= CNT_W'(H_TOTAL - 1);
         y           <= CNT_W'(V_TOTAL - 1);
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         disp_en     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_ce      <= step;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (step) begin
            div_cnt     <= '0;
            x           <= nxt.x;
            y           <= nxt.y;
            hsync       <= hs_active(nxt) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_active(nxt) ? VSYNC_POL : ~VSYNC_POL;
            disp_en     <= visible(nxt);
            line_start  <= (nxt.x == '0);
            frame_start <= (nxt.x == '0) && (nxt.y == '0);
         end else if (enable) begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

`ifdef VGA_TIMING_PREFETCH_EN
   // pre_* always hold the position one step ahead of x/y; after reset that is
   // (0,0) because x/y start on the last pixel of the frame.
   pos_t pre_nxt;
   assign pre_nxt = advance(nxt);

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         pre_x     <= '0;
         pre_y     <= '0;
         pre_valid <= 1'b1;
      end else if (step) begin
         pre_x     <= pre_nxt.x;
         pre_y     <= pre_nxt.y;
         pre_valid <= visible(pre_nxt);
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Self-checking bench for vga_timing_gen using a reduced 20x6 raster so that
//   several frames fit in a short run. Two instances share clock, reset and
//   enable: dut_a (CLK_DIV=2, active-low syncs) and dut_b (CLK_DIV=1,
//   active-high syncs). A reference model derives every output from the number
//   of enabled clock edges since reset; a negedge process compares both
//   instances to it on every cycle. Directed phases pin literal values: reset
//   state, first pixel, frame/line statistics, freeze/resume and asynchronous
//   reset inside hsync. A randomized phase toggles enable and pulses reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

   localparam int H_ACTIVE = 20, H_FP = 3, H_SYNC = 5, H_BP = 4;
   localparam int V_ACTIVE = 6,  V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 32
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 13
   localparam int FRAME    = H_TOTAL * V_TOTAL;                 // 416
   localparam int CNT_W    = 6;

   logic clk_50 = 1'b0;
   logic reset_n;
   logic enable;

   logic             a_ce, a_hs, a_vs, a_de, a_ls, a_fs, a_pv;
   logic [CNT_W-1:0] a_x, a_y, a_px, a_py;
   logic             b_ce, b_hs, b_vs, b_de, b_ls, b_fs, b_pv;
   logic [CNT_W-1:0] b_x, b_y, b_px, b_py;

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CNT_W)
   ) dut_a (
      .clk_50(clk_50), .reset_n(reset_n), .enable(enable),
      .pix_ce(a_ce), .hsync(a_hs), .vsync(a_vs), .disp_en(a_de),
      .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .pre_x(a_px), .pre_y(a_py), .pre_valid(a_pv)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CNT_W)
   ) dut_b (
      .clk_50(clk_50), .reset_n(reset_n), .enable(enable),
      .pix_ce(b_ce), .hsync(b_hs), .vsync(b_vs), .disp_en(b_de),
      .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .pre_x(b_px), .pre_y(b_py), .pre_valid(b_pv)
`endif
   );

`ifndef VGA_TIMING_PREFETCH_EN
   assign a_px = '0; assign a_py = '0; assign a_pv = 1'b0;
   assign b_px = '0; assign b_py = '0; assign b_pv = 1'b0;
`endif

   always #5 clk_50 = ~clk_50;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_n counts enabled clock edges since reset; m_en records whether the most
   // recent edge was enabled. Everything else follows by arithmetic.
   int m_n;
   bit m_en;

   always @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         m_n  <= 0;
         m_en <= 1'b0;
      end else begin
         m_en <= enable;
         if (enable) m_n <= m_n + 1;
      end
   end

   typedef struct {
      int x, y, px, py;
      bit ce, hs, vs, de, ls, fs, pv;
   } exp_t;

   function automatic exp_t model(input int n, input bit en_last, input int cdiv,
                                  input bit hpol, input bit vpol);
      exp_t e;
      int   steps, idx, pidx;
      steps = n / cdiv;                       // pixel advances so far
      idx   = (steps + FRAME - 1) % FRAME;    // reset position is the last pixel
      pidx  = steps % FRAME;
      e.x   = idx % H_TOTAL;
      e.y   = idx / H_TOTAL;
      e.px  = pidx % H_TOTAL;
      e.py  = pidx / H_TOTAL;
      e.ce  = en_last && (n > 0) && (n % cdiv == 0);
      e.hs  = (e.x >= H_ACTIVE + H_FP && e.x < H_ACTIVE + H_FP + H_SYNC) ? hpol : !hpol;
      e.vs  = (e.y >= V_ACTIVE + V_FP && e.y < V_ACTIVE + V_FP + V_SYNC) ? vpol : !vpol;
      e.de  = (e.x < H_ACTIVE) && (e.y < V_ACTIVE);
      e.pv  = (e.px < H_ACTIVE) && (e.py < V_ACTIVE);
      e.ls  = e.ce && (e.x == 0);
      e.fs  = e.ls && (e.y == 0);
      return e;
   endfunction

   task automatic cmp_dut(input string p, input exp_t e, input int x, input int y,
                          input bit ce, input bit hs, input bit vs, input bit de,
                          input bit ls, input bit fs, input int px, input int py,
                          input bit pv);
      check({p, "_x"}, x, e.x);
      check({p, "_y"}, y, e.y);
      check({p, "_pix_ce"}, int'(ce), int'(e.ce));
      check({p, "_hsync"}, int'(hs), int'(e.hs));
      check({p, "_vsync"}, int'(vs), int'(e.vs));
      check({p, "_disp_en"}, int'(de), int'(e.de));
      check({p, "_line_start"}, int'(ls), int'(e.ls));
      check({p, "_frame_start"}, int'(fs), int'(e.fs));
`ifdef VGA_TIMING_PREFETCH_EN
      check({p, "_pre_x"}, px, e.px);
      check({p, "_pre_y"}, py, e.py);
      check({p, "_pre_valid"}, int'(pv), int'(e.pv));
`endif
   endtask

   always @(negedge clk_50) begin
      cmp_dut("a", model(m_n, m_en, 2, 1'b0, 1'b0), int'(a_x), int'(a_y), a_ce, a_hs,
              a_vs, a_de, a_ls, a_fs, int'(a_px), int'(a_py), a_pv);
      cmp_dut("b", model(m_n, m_en, 1, 1'b1, 1'b1), int'(b_x), int'(b_y), b_ce, b_hs,
              b_vs, b_de, b_ls, b_fs, int'(b_px), int'(b_py), b_pv);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   // Advance until dut_a shows pix_ce (optionally at a given position).
   task automatic wait_a(input string name, input int budget, input bit match_pos,
                         input int wx, input int wy);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick();
         if (a_ce && (!match_pos || (int'(a_x) == wx && int'(a_y) == wy))) hit = 1'b1;
      end
      if (!hit) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic check_first_pixel(input string p);
      check({p, "_x"}, int'(a_x), 0);
      check({p, "_y"}, int'(a_y), 0);
      check({p, "_disp_en"}, int'(a_de), 1);
      check({p, "_frame_start"}, int'(a_fs), 1);
      check({p, "_line_start"}, int'(a_ls), 1);
      tick();
      check({p, "_fs_cleared"}, int'(a_fs), 0);
      check({p, "_ls_cleared"}, int'(a_ls), 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int de_cnt, ce_cnt, hs_cnt, lines_seen, vs_lines, last_fs;
      bit hs_prev;

      reset_n = 1'b1;
      enable  = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) tick();

      // Reset state, literal values.
      check("rst_a_x", int'(a_x), 31);
      check("rst_a_y", int'(a_y), 12);
      check("rst_a_hsync", int'(a_hs), 1);
      check("rst_a_vsync", int'(a_vs), 1);
      check("rst_b_hsync", int'(b_hs), 0);
      check("rst_a_disp_en", int'(a_de), 0);
      check("rst_a_pix_ce", int'(a_ce), 0);
`ifdef VGA_TIMING_PREFETCH_EN
      check("rst_a_pre_x", int'(a_px), 0);
      check("rst_a_pre_y", int'(a_py), 0);
      check("rst_a_pre_valid", int'(a_pv), 1);
`endif

      // Release reset: first pix_ce lands on (0,0) with both strobes.
      reset_n = 1'b1;
      enable  = 1'b1;
      wait_a("first_ce", 10, 1'b0, 0, 0);
      check_first_pixel("first");

      // Two frames with enable held: frame period, visible pixel count,
      // hsync width/position, vsync lines.
      de_cnt = 1; ce_cnt = 1; hs_cnt = 0; lines_seen = 1; vs_lines = 0;
      last_fs = 0; hs_prev = a_hs;
      for (int cyc = 2; cyc <= 2 * FRAME * 2; cyc++) begin
         tick();
         if (a_fs) begin
            check("frame_period", cyc - last_fs, 832);
            check("disp_en_per_frame", de_cnt, 120);
            check("pix_ce_per_frame", ce_cnt, 416);
            check("vsync_lines", vs_lines, 2);
            last_fs = cyc; de_cnt = 0; ce_cnt = 0; vs_lines = 0;
         end
         if (a_ls) begin
            check("hsync_width", hs_cnt, 5);
            hs_cnt = 0;
            lines_seen++;
            if (!a_vs) begin
               if (vs_lines == 0) check("vsync_first_y", int'(a_y), 8);
               vs_lines++;
            end
         end
         if (a_ce) begin
            ce_cnt++;
            if (a_de) de_cnt++;
            if (!a_hs) hs_cnt++;
            if (!a_hs && hs_prev) check("hsync_first_x", int'(a_x), 23);
            hs_prev = a_hs;
         end
      end
      check("lines_in_two_frames", lines_seen, 2 * V_TOTAL + 1);

      // Freeze at (10,3) for 37 cycles, then resume on the very next pixel.
      wait_a("freeze_pos", 1000, 1'b1, 10, 3);
      enable = 1'b0;
      for (int i = 0; i < 37; i++) begin
         tick();
         check("freeze_x", int'(a_x), 10);
         check("freeze_y", int'(a_y), 3);
         check("freeze_pix_ce", int'(a_ce), 0);
      end
      enable = 1'b1;
      wait_a("resume_ce", 4, 1'b0, 0, 0);
      check("resume_x", int'(a_x), 11);
      check("resume_y", int'(a_y), 3);

      // Asynchronous reset inside hsync: sync drops without waiting for a clock.
      wait_a("hsync_pos", 200, 1'b1, 26, 3);
      check("in_hsync_a", int'(a_hs), 0);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_a_hsync", int'(a_hs), 1);
      check("async_rst_b_hsync", int'(b_hs), 0);
      check("async_rst_a_x", int'(a_x), 31);
      check("async_rst_a_y", int'(a_y), 12);
      repeat (3) tick();
      reset_n = 1'b1;
      wait_a("restart_ce", 10, 1'b0, 0, 0);
      check_first_pixel("restart");

      // Randomized enable with occasional reset pulses; the model checks all.
      for (int i = 0; i < 6000; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 999) == 0) begin
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
         end
         tick();
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
